lcv_mul_acc_pipe: RTL and testbench



---
 rtl/lcv_mul_acc_pkg.sv | 37 +++
 rtl/lcv_mul_acc_s3.sv | 87 ++++++++
 rtl/lcv_mul_acc_pipe.sv | 97 +++++++++
 tb/tb_lcv_mul_acc_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcv_mul_acc_pkg.sv
// rtl/lcv_mul_acc_pkg.sv - shared types and clamp helper for the pipelined multiply-accumulate unit
package lcv_mul_acc_pkg;

  typedef enum logic [1:0] {
    OP_MAC  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MSUB = 2'd2,
    OP_PASS = 2'd3
  } op_t;

  typedef struct packed {
    logic vld;
    op_t  op;
  } stage_ctl_t;

  // Wide enough for ACC_WIDTH+2 results up to ACC_WIDTH = 127.
  localparam int unsigned CLAMP_W = 130;

  function automatic logic signed [CLAMP_W-1:0] sat_clamp(
    input logic signed [CLAMP_W-1:0] value,
    input int unsigned               width
  );
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    logic signed [CLAMP_W-1:0] res;
    hi  = (CLAMP_W'(1) << (width - 1)) - CLAMP_W'(1);
    lo  = ~hi;
    res = value;
    if (value > hi) begin
      res = hi;
    end else if (value < lo) begin
      res = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/lcv_mul_acc_s3.sv
// rtl/lcv_mul_acc_s3.sv - final stage: accumulate/saturate, overflow flag and result register
module lcv_mul_acc_s3 import lcv_mul_acc_pkg::*; #(
  parameter int ACC_WIDTH = 48,
  parameter bit SAT       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        advance,
  input  logic                        acc_clr,
  input  stage_ctl_t                  ctl,
  input  logic signed [ACC_WIDTH+1:0] p,
  input  logic signed [ACC_WIDTH-1:0] c,
  output logic                        out_valid,
  output logic signed [ACC_WIDTH-1:0] outp,
  output logic                        ovf
);

  localparam int RW = ACC_WIDTH + 2;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] outp_q, outp_d;
  logic                        out_valid_q, out_valid_d;
  logic                        ovf_q, ovf_d;

  logic signed [RW-1:0]        acc_x, c_x, r;
  logic signed [CLAMP_W-1:0]   r_wide, r_clamped;
  logic signed [ACC_WIDTH-1:0] r_final;
  logic                        out_of_range;

  // Two guard bits keep acc +/- p exact before range check.
  always_comb begin
    acc_x = {{2{acc_q[ACC_WIDTH-1]}}, acc_q};
    c_x   = {{2{c[ACC_WIDTH-1]}}, c};
    case (ctl.op)
      OP_MAC:  r = acc_x + p;
      OP_MSUB: r = acc_x - p;
      default: r = p + c_x;
    endcase
    r_wide       = {{(CLAMP_W - RW){r[RW-1]}}, r};
    r_clamped    = sat_clamp(r_wide, ACC_WIDTH);
    out_of_range = (r_clamped != r_wide);
    r_final      = SAT ? r_clamped[ACC_WIDTH-1:0] : r[ACC_WIDTH-1:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    outp_d      = outp_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (advance) begin
      out_valid_d = ctl.vld;
      if (ctl.vld) begin
        outp_d = r_final;
        if (ctl.op != OP_PASS) begin
          acc_d = r_final;
        end
        if (out_of_range) begin
          ovf_d = 1'b1;
        end
      end
    end
    // Clear wins over the update but the beat's own result uses the old acc.
    if (acc_clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      outp_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      outp_q      <= outp_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign outp      = outp_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/lcv_mul_acc_pipe.sv
// rtl/lcv_mul_acc_pipe.sv - 3-stage signed multiply-accumulate with valid/ready flow control
module lcv_mul_acc_pipe import lcv_mul_acc_pkg::*; #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int ACC_WIDTH = 48,
  parameter bit SAT       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_A-1:0]   a,
  input  logic signed [WIDTH_B-1:0]   b,
  input  logic signed [ACC_WIDTH-1:0] c,
  input  logic [1:0]                  op,
  input  logic                        acc_clr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] outp,
  output logic                        ovf
);

  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int RW = ACC_WIDTH + 2;

  stage_ctl_t                  s1_ctl_q, s1_ctl_d;
  stage_ctl_t                  s2_ctl_q, s2_ctl_d;
  logic signed [WIDTH_A-1:0]   a_q, a_d;
  logic signed [WIDTH_B-1:0]   b_q, b_d;
  logic signed [ACC_WIDTH-1:0] c1_q, c1_d;
  logic signed [ACC_WIDTH-1:0] c2_q, c2_d;
  logic signed [RW-1:0]        p_q, p_d;
  logic signed [PW-1:0]        prod;
  logic                        advance;

  // Global stall: every stage holds while the result is not taken.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  always_comb begin
    s1_ctl_d = s1_ctl_q;
    s2_ctl_d = s2_ctl_q;
    a_d      = a_q;
    b_d      = b_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    p_d      = p_q;
    prod     = a_q * b_q;
    if (advance) begin
      s1_ctl_d.vld = in_valid;
      s1_ctl_d.op  = op_t'(op);
      a_d          = a;
      b_d          = b;
      c1_d         = c;
      s2_ctl_d     = s1_ctl_q;
      p_d          = {{(RW - PW){prod[PW-1]}}, prod};
      c2_d         = c1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ctl_q <= '0;
      s2_ctl_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      p_q      <= '0;
    end else begin
      s1_ctl_q <= s1_ctl_d;
      s2_ctl_q <= s2_ctl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      p_q      <= p_d;
    end
  end

  lcv_mul_acc_s3 #(
    .ACC_WIDTH(ACC_WIDTH),
    .SAT      (SAT)
  ) u_s3 (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .acc_clr  (acc_clr),
    .ctl      (s2_ctl_q),
    .p        (p_q),
    .c        (c2_q),
    .out_valid(out_valid),
    .outp     (outp),
    .ovf      (ovf)
  );

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// tb/tb_lcv_mul_acc_pipe.sv - directed vector bench for lcv_mul_acc_pipe (48-bit wrap, 33-bit sat and wrap)
module tb_lcv_mul_acc_pipe;
  import lcv_mul_acc_pkg::*;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [47:0] c;
  logic [1:0]         op;
  logic               acc_clr;
  logic               out_ready;

  logic               in_ready_48, out_valid_48, ovf_48;
  logic signed [47:0] outp_48;
  logic               in_ready_s, out_valid_s, ovf_s;
  logic signed [32:0] outp_s;
  logic               in_ready_w, out_valid_w, ovf_w;
  logic signed [32:0] outp_w;

  int n_assert = 0;
  int n_fail   = 0;

  lcv_mul_acc_pipe #(.WIDTH_A(16), .WIDTH_B(16), .ACC_WIDTH(48), .SAT(1'b0)) u_d48 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_48),
    .a(a), .b(b), .c(c), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid_48), .out_ready(out_ready), .outp(outp_48), .ovf(ovf_48)
  );

  lcv_mul_acc_pipe #(.WIDTH_A(16), .WIDTH_B(16), .ACC_WIDTH(33), .SAT(1'b1)) u_s33 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .c(c[32:0]), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid_s), .out_ready(out_ready), .outp(outp_s), .ovf(ovf_s)
  );

  lcv_mul_acc_pipe #(.WIDTH_A(16), .WIDTH_B(16), .ACC_WIDTH(33), .SAT(1'b0)) u_w33 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .c(c[32:0]), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid_w), .out_ready(out_ready), .outp(outp_w), .ovf(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    op_t     op;
    int      a;
    int      b;
    longint  c;
    longint  exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input op_t o, input int aa, input int bb, input longint cc);
    in_valid = v;
    op       = o;
    a        = 16'(aa);
    b        = 16'(bb);
    c        = 48'(cc);
  endtask

  task automatic do_reset();
    drive(1'b0, OP_MAC, 0, 0, 0);
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int     sent;
    int     recv;
    longint exp_s[4];
    longint exp_w[4];

    tbl[0] = '{OP_PASS,      3,    -4, 100, 88};
    tbl[1] = '{OP_LOAD,      2,     5,   1, 11};
    tbl[2] = '{OP_MAC,       3,     3,   0, 20};
    tbl[3] = '{OP_MAC,      -1,     4,   0, 16};
    tbl[4] = '{OP_MSUB,      2,     3,   0, 10};
    tbl[5] = '{OP_PASS,      1,     1,  -5, -4};
    tbl[6] = '{OP_MAC,       0,     7,   0, 10};
    tbl[7] = '{OP_LOAD,   -100,   100,   0, -10000};
    tbl[8] = '{OP_MSUB,     -2,    -3,   0, -10006};
    tbl[9] = '{OP_MAC,  -32768, 32767,   0, -1073719062};

    // reset state on all three instances
    do_reset();
    chk("rst_out_valid_48", out_valid_48, 0);
    chk("rst_outp_48", outp_48, 0);
    chk("rst_ovf_48", ovf_48, 0);
    chk("rst_in_ready_48", in_ready_48, 1);
    chk("rst_out_valid_s", out_valid_s, 0);
    chk("rst_outp_s", outp_s, 0);
    chk("rst_in_ready_s", in_ready_s, 1);
    chk("rst_out_valid_w", out_valid_w, 0);
    chk("rst_ovf_w", ovf_w, 0);
    chk("rst_in_ready_w", in_ready_w, 1);

    // table: beat k presented in cycle k, its result visible in cycle k+3
    for (int k = 0; k <= 12; k++) begin
      if (k < 10) drive(1'b1, tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].c);
      else        drive(1'b0, OP_MAC, 0, 0, 0);
      tick();
      if (k >= 2 && k - 2 < 10) begin
        chk($sformatf("tbl_valid_%0d", k - 2), out_valid_48, 1);
        chk($sformatf("tbl_outp_%0d", k - 2), outp_48, tbl[k - 2].exp);
        chk($sformatf("tbl_ovf_%0d", k - 2), ovf_48, 0);
      end else begin
        chk($sformatf("tbl_idle_valid_c%0d", k + 1), out_valid_48, 0);
      end
    end

    // backpressure: six MAC(1,1) beats, out_ready low in cycles 4..7
    do_reset();
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      drive(sent < 6, OP_MAC, 1, 1, 0);
      #1;
      chk($sformatf("bp_in_ready_c%0d", cyc), in_ready_48, (cyc >= 4 && cyc <= 7) ? 0 : 1);
      if (out_valid_48) chk($sformatf("bp_outp_c%0d", cyc), outp_48, recv + 1);
      if (out_valid_48 && out_ready) recv++;
      if (in_valid && in_ready_48) sent++;
      tick();
    end
    chk("bp_sent", sent, 6);
    chk("bp_recv", recv, 6);
    chk("bp_final_outp", outp_48, 6);
    chk("bp_no_dup_valid", out_valid_48, 0);

    // saturation vs wrap at ACC_WIDTH=33
    exp_s = '{64'd1073741824, 64'd2147483648, 64'd3221225472, 64'd4294967295};
    exp_w = '{64'd1073741824, 64'd2147483648, 64'd3221225472, -64'sd4294967296};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, OP_MAC, -32768, -32768, 0);
      else       drive(1'b0, OP_MAC, 0, 0, 0);
      tick();
      if (k >= 2) begin
        chk($sformatf("sat_outp_%0d", k - 1), outp_s, exp_s[k - 2]);
        chk($sformatf("sat_ovf_%0d", k - 1), ovf_s, (k == 5) ? 1 : 0);
        chk($sformatf("wrap_outp_%0d", k - 1), outp_w, exp_w[k - 2]);
        chk($sformatf("wrap_ovf_%0d", k - 1), ovf_w, (k == 5) ? 1 : 0);
        chk($sformatf("w48_outp_%0d", k - 1), outp_48, 64'(k - 1) * 64'd1073741824);
      end
    end
    drive(1'b1, OP_PASS, 0, 0, 0);
    tick();
    drive(1'b0, OP_MAC, 0, 0, 0);
    tick();
    tick();
    chk("sat_pass_outp", outp_s, 0);
    chk("sat_ovf_sticky", ovf_s, 1);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("sat_ovf_cleared", ovf_s, 0);
    chk("wrap_ovf_cleared", ovf_w, 0);
    drive(1'b1, OP_MAC, 1, 1, 0);
    tick();
    drive(1'b0, OP_MAC, 0, 0, 0);
    tick();
    tick();
    chk("sat_after_clr_outp", outp_s, 1);

    // acc_clr in the same cycle the MAC sits in S3
    do_reset();
    drive(1'b1, OP_LOAD, 0, 0, 50);
    tick();
    drive(1'b1, OP_MAC, 1, 1, 0);
    tick();
    drive(1'b1, OP_MAC, 2, 2, 0);
    tick();
    drive(1'b0, OP_MAC, 0, 0, 0);
    acc_clr = 1'b1;
    chk("clr_load_outp", outp_48, 50);
    tick();
    acc_clr = 1'b0;
    chk("clr_mac_outp", outp_48, 51);
    chk("clr_ovf", ovf_48, 0);
    tick();
    chk("clr_next_outp", outp_48, 4);
    chk("clr_next_valid", out_valid_48, 1);

    // reset with two beats in flight
    do_reset();
    drive(1'b1, OP_LOAD, 0, 0, 77);
    tick();
    drive(1'b0, OP_MAC, 0, 0, 0);
    tick();
    tick();
    chk("rmf_pre_outp", outp_48, 77);
    drive(1'b1, OP_LOAD, 0, 0, 5);
    tick();
    drive(1'b1, OP_MAC, 3, 3, 0);
    tick();
    drive(1'b0, OP_MAC, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rmf_no_valid_%0d", k), out_valid_48, 0);
      tick();
    end
    chk("rmf_outp", outp_48, 0);
    chk("rmf_in_ready", in_ready_48, 1);
    drive(1'b1, OP_MAC, 1, 1, 0);
    tick();
    drive(1'b0, OP_MAC, 0, 0, 0);
    tick();
    tick();
    chk("rmf_acc_zeroed", outp_48, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
